// File: rtl/rc_channel_poller.sv
// rtl/rc_channel_poller.sv - Wishbone master polling the 6-channel RC PWM decoder
// Optional failsafe (bad-poll counter, forced outputs) enabled by RC_POLLER_FAILSAFE_EN.
module rc_channel_poller #(
  parameter int clockFreq      = 100_000_000,
  parameter int POLL_HZ        = 250,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BASE_ADDR      = 0,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int FAILSAFE_US    = 1000,
  parameter int FAILSAFE_POLLS = 25
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic                    wbm_we_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_cyc_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  output logic [95:0]             o_ch_us,
  output logic [5:0]              o_valid,
  output logic                    o_update,
  output logic                    o_failsafe
);
  localparam int P  = clockFreq / POLL_HZ;
  localparam int TW = (P > 1) ? $clog2(P) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(P - 1);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_STAT = 2'd1;
  localparam logic [1:0] S_RD_CH   = 2'd2;
  localparam logic [1:0] S_COMMIT  = 2'd3;
  localparam logic [15:0] FS_US = 16'(FAILSAFE_US);
  localparam logic [15:0] LO_US = 16'(MIN_US);
  localparam logic [15:0] HI_US = 16'(MAX_US);
  localparam logic [7:0]  WD_LAST = 8'd254;

  logic [1:0]            state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic                  pending_q, pending_d;
  logic                  cyc_q, cyc_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [7:0]            wd_q, wd_d;
  logic [2:0]            idx_q, idx_d;
  logic [5:0]            stat_q, stat_d;
  logic [5:0]            valid_q, valid_d;
  logic [95:0]           shadow_q, shadow_d;
  logic [95:0]           ch_q, ch_d;
  logic [5:0]            ov_q, ov_d;
  logic                  upd_q, upd_d;
`ifdef RC_POLLER_FAILSAFE_EN
  localparam logic [7:0] FP = 8'(FAILSAFE_POLLS);
  logic [7:0]            cnt_q, cnt_d;
  logic                  fs_q, fs_d;
`else
  logic unused_fs_polls;
  assign unused_fs_polls = ^8'(FAILSAFE_POLLS);
`endif

  logic [15:0] rd_us;
  logic        rd_done, rd_ok, rd_in_range;
  logic        unused_dat;

  assign rd_us       = wbm_dat_i[15:0];
  assign unused_dat  = ^wbm_dat_i[DATA_WIDTH-1:16];
  // The watchdog terminates a read on its 255th strobe cycle; err always overrides ack.
  assign rd_done     = cyc_q & (wbm_ack_i | wbm_err_i | (wd_q == WD_LAST));
  assign rd_ok       = wbm_ack_i & ~wbm_err_i;
  assign rd_in_range = ~rd_us[15] & (rd_us >= 16'd800) & (rd_us <= 16'd2200);

  function automatic logic [15:0] clamp_us(input logic [15:0] v);
    if (v < LO_US) return LO_US;
    else if (v > HI_US) return HI_US;
    else return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    tick_d    = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    pending_d = pending_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    wd_d      = cyc_q ? wd_q + 8'd1 : 8'd0;
    idx_d     = idx_q;
    stat_d    = stat_q;
    valid_d   = valid_q;
    shadow_d  = shadow_q;
    ch_d      = ch_q;
    ov_d      = ov_q;
    upd_d     = 1'b0;
`ifdef RC_POLLER_FAILSAFE_EN
    cnt_d     = cnt_q;
    fs_d      = fs_q;
`endif
    if (state_q == S_IDLE && pending_q) pending_d = 1'b0;
    if (tick_q == TICK_LAST) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d = S_RD_STAT;
          cyc_d   = 1'b1;
          wd_d    = 8'd0;
          adr_d   = ADDR_WIDTH'(BASE_ADDR + 24);
          valid_d = '0;
          stat_d  = '0;
        end
      end
      S_RD_STAT: begin
        if (rd_done) begin
          cyc_d = 1'b0;
          idx_d = 3'd0;
          if (rd_ok) begin
            stat_d  = wbm_dat_i[5:0];
            state_d = S_RD_CH;
          end else begin
            state_d = S_COMMIT;
          end
        end
      end
      S_RD_CH: begin
        if (cyc_q) begin
          if (rd_done) begin
            cyc_d = 1'b0;
            if (rd_ok && rd_in_range) begin
              valid_d[idx_q]           = 1'b1;
              shadow_d[16*idx_q +: 16] = clamp_us(rd_us);
            end
            if (idx_q == 3'd5) state_d = S_COMMIT;
            else idx_d = idx_q + 3'd1;
          end
        end else if (stat_q[idx_q]) begin
          // This cycle doubles as the mandatory idle gap before the next read.
          cyc_d = 1'b1;
          wd_d  = 8'd0;
          adr_d = ADDR_WIDTH'(BASE_ADDR + 4 * int'(idx_q));
        end else if (idx_q == 3'd5) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        ov_d    = valid_q;
        upd_d   = 1'b1;
`ifdef RC_POLLER_FAILSAFE_EN
        if (&valid_q) begin
          cnt_d = 8'd0;
          fs_d  = 1'b0;
        end else begin
          if (cnt_q != FP) cnt_d = cnt_q + 8'd1;
          if (cnt_d == FP) fs_d = 1'b1;
        end
        ch_d = fs_d ? {6{FS_US}} : shadow_q;
`else
        ch_d = shadow_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      pending_q <= 1'b0;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      wd_q      <= 8'd0;
      idx_q     <= 3'd0;
      stat_q    <= 6'd0;
      valid_q   <= 6'd0;
      shadow_q  <= {6{FS_US}};
      ch_q      <= {6{FS_US}};
      ov_q      <= 6'd0;
      upd_q     <= 1'b0;
`ifdef RC_POLLER_FAILSAFE_EN
      cnt_q     <= 8'd0;
      fs_q      <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
      wd_q      <= wd_d;
      idx_q     <= idx_d;
      stat_q    <= stat_d;
      valid_q   <= valid_d;
      shadow_q  <= shadow_d;
      ch_q      <= ch_d;
      ov_q      <= ov_d;
      upd_q     <= upd_d;
`ifdef RC_POLLER_FAILSAFE_EN
      cnt_q     <= cnt_d;
      fs_q      <= fs_d;
`endif
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = {(DATA_WIDTH/8){cyc_q}};
  assign wbm_stb_o = cyc_q;
  assign wbm_cyc_o = cyc_q;
  assign o_ch_us   = ch_q;
  assign o_valid   = ov_q;
  assign o_update  = upd_q;
`ifdef RC_POLLER_FAILSAFE_EN
  assign o_failsafe = fs_q;
`else
  assign o_failsafe = 1'b0;
`endif
endmodule

// File: tb/tb_rc_channel_poller.sv
// tb/tb_rc_channel_poller.sv - scoreboard bench for rc_channel_poller
// Registered-ack decoder slave model, random polls, reference model of poll outcome.
module tb_rc_channel_poller;
  localparam int CLK_HZ = 1000;
  localparam int PHZ    = 10;
  localparam int BASE   = 256;
  localparam int MINU   = 1000;
  localparam int MAXU   = 2000;
  localparam int FSU    = 1000;
  localparam int FSP    = 25;
`ifdef RC_POLLER_FAILSAFE_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  typedef struct packed {
    logic [95:0] ch;
    logic [5:0]  valid;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr, dat;
  logic        we, stb, cyc, ack, err;
  logic [3:0]  sel;
  logic [95:0] ch;
  logic [5:0]  valid;
  logic        upd, fs;

  logic [31:0] cfg_val  [8];
  logic        cfg_err  [8];
  logic        cfg_hang [8];

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  exp_t        mon_e;
  logic [15:0] m_sh [6];
  int          m_cnt;
  logic        m_fs;
  logic        rst_test = 1'b0;
  int          tests = 0;
  int          fails = 0;

  rc_channel_poller #(
    .clockFreq(CLK_HZ), .POLL_HZ(PHZ), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .BASE_ADDR(BASE), .MIN_US(MINU), .MAX_US(MAXU), .FAILSAFE_US(FSU),
    .FAILSAFE_POLLS(FSP)
  ) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .wbm_adr_o(adr), .wbm_dat_i(dat), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_stb_o(stb), .wbm_cyc_o(cyc), .wbm_ack_i(ack), .wbm_err_i(err),
    .o_ch_us(ch), .o_valid(valid), .o_update(upd), .o_failsafe(fs)
  );

  always #5 clk = ~clk;

  logic [2:0]  slot;
  logic [31:0] off;
  always_comb begin
    off  = adr - 32'(BASE);
    slot = 3'd7;
    if (off[1:0] == 2'b00 && off < 32'd28) slot = off[4:2];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
      err <= 1'b0;
      dat <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (cyc && stb && !ack && !err) begin
        dat <= (slot == 3'd7) ? 32'hDEAD_BEEF : cfg_val[slot];
        if (slot == 3'd7 || cfg_err[slot]) err <= 1'b1;
        else if (!cfg_hang[slot]) ack <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 6; n++) m_sh[n] = 16'(FSU);
    m_cnt = 0;
    m_fs  = FE;
  endtask

  task automatic clear_faults();
    for (int k = 0; k < 8; k++) begin
      cfg_err[k]  = 1'b0;
      cfg_hang[k] = 1'b0;
    end
    cfg_val[7] = '0;
  endtask

  task automatic set_cfg(input logic [5:0] st, input logic [95:0] v);
    clear_faults();
    cfg_val[6] = {26'h0, st};
    for (int n = 0; n < 6; n++) cfg_val[n] = {16'h0, v[16*n +: 16]};
  endtask

  task automatic gen_random();
    logic [15:0] v;
    clear_faults();
    cfg_val[6] = {26'($urandom), ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom)};
    cfg_err[6] = ($urandom_range(0, 24) == 0);
    for (int n = 0; n < 6; n++) begin
      case ($urandom_range(0, 5))
        0: v = 16'($urandom_range(700, 2300));
        1: v = 16'($urandom_range(1000, 2000));
        2: v = 16'h8000 | 16'($urandom_range(800, 2200));
        3: v = 16'($urandom_range(795, 805));
        4: v = 16'($urandom_range(2195, 2205));
        default: v = 16'($urandom);
      endcase
      cfg_val[n] = {16'($urandom), v};
      cfg_err[n] = ($urandom_range(0, 24) == 0);
    end
    if ($urandom_range(0, 9) == 0) cfg_hang[$urandom_range(0, 6)] = 1'b1;
  endtask

  // Outcome of one poll from the current slave contents.
  task automatic push_expect();
    exp_t        e;
    logic [5:0]  v, st;
    logic [15:0] d;
    v  = '0;
    st = '0;
    addr_q.push_back(32'(BASE + 24));
    if (!cfg_err[6] && !cfg_hang[6]) st = cfg_val[6][5:0];
    for (int n = 0; n < 6; n++) begin
      if (st[n]) begin
        addr_q.push_back(32'(BASE + 4 * n));
        d = cfg_val[n][15:0];
        if (!cfg_err[n] && !cfg_hang[n] && d >= 16'd800 && d <= 16'd2200) begin
          v[n]    = 1'b1;
          m_sh[n] = (d < 16'(MINU)) ? 16'(MINU) : (d > 16'(MAXU)) ? 16'(MAXU) : d;
        end
      end
    end
    if (FE) begin
      if (v == 6'h3F) begin
        m_cnt = 0;
        m_fs  = 1'b0;
      end else begin
        if (m_cnt < FSP) m_cnt++;
        if (m_cnt == FSP) m_fs = 1'b1;
      end
    end
    for (int n = 0; n < 6; n++) e.ch[16*n +: 16] = m_fs ? 16'(FSU) : m_sh[n];
    e.valid = v;
    e.fs    = m_fs;
    exp_q.push_back(e);
  endtask

  task automatic wait_update();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!upd && t < 3000);
    if (!upd) begin
      tests++;
      fails++;
      $display("FAIL update_timeout: no o_update within %0d cycles", t);
    end
  endtask

  task automatic run_poll();
    push_expect();
    wait_update();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_adr"}, 96'(adr), 96'd0);
    check({tag, "_bus"}, 96'({cyc, stb, we, sel}), 96'd0);
    check({tag, "_ch"}, ch, {6{16'(FSU)}});
    check({tag, "_valid"}, 96'(valid), 96'd0);
    check({tag, "_update"}, 96'(upd), 96'd0);
    check({tag, "_failsafe"}, 96'(fs), 96'(FE));
  endtask

  initial begin : scoreboard
    forever begin
      @(negedge clk);
      if (upd) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_update: o_update high with no poll expected");
        end else begin
          mon_e = exp_q.pop_front();
          check("ch_us", ch, mon_e.ch);
          check("valid", 96'(valid), 96'(mon_e.valid));
          check("failsafe", 96'(fs), 96'(mon_e.fs));
        end
      end
    end
  end

  logic       stb_prev = 1'b0;
  int         blen = 0;
  logic [2:0] bslot = 3'd7;
  initial begin : bus_monitor
    forever begin
      @(negedge clk);
      if (stb && !stb_prev && !rst_test) begin
        if (addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_read: adr %0h with no read expected", adr);
        end else begin
          check("rd_addr", 96'(adr), 96'(addr_q.pop_front()));
        end
        check("rd_ctrl", 96'({cyc, we, sel}), 96'(6'h2F));
        blen  = 0;
        bslot = slot;
      end
      if (stb) blen++;
      if (!stb && stb_prev && !rst_test)
        check("stb_len", 96'(blen), (bslot != 3'd7 && cfg_hang[bslot]) ? 96'd255 : 96'd2);
      stb_prev = stb;
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int t;
    model_reset();
    set_cfg(6'h3F, {16'd2000, 16'd1000, 16'd2100, 16'd900, 16'd1200, 16'd1500});
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    run_poll();

    set_cfg(6'h3E, {16'd1500, 16'd1500, 16'd1500, 16'd1500, 16'd1500, 16'hC000});
    run_poll();
    set_cfg(6'h3F, {6{16'd1400}});
    run_poll();
    for (int i = 0; i < FSP; i++) begin
      set_cfg(6'h3F, {16'd1500, 16'd1500, 16'd1500, 16'h85DC, 16'd1500, 16'd1500});
      run_poll();
    end
    set_cfg(6'h3F, {16'd1100, 16'd1200, 16'd1300, 16'd1400, 16'd1600, 16'd1700});
    run_poll();
    set_cfg(6'h3F, {6{16'd1800}});
    cfg_err[6] = 1'b1;
    run_poll();
    set_cfg(6'h3F, {16'd1950, 16'd1850, 16'd1750, 16'd1650, 16'd1550, 16'd1450});
    cfg_hang[3] = 1'b1;
    run_poll();
    for (int i = 0; i < 30; i++) begin
      gen_random();
      run_poll();
    end

    rst_test = 1'b1;
    set_cfg(6'h3F, {6{16'd1234}});
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!stb && t < 500);
    check("rst_wait_stb", 96'(stb), 96'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    repeat (5) @(negedge clk);
    model_reset();
    addr_q.delete();
    rst_n = 1'b1;
    rst_test = 1'b0;
    set_cfg(6'h3F, {16'd1900, 16'd1800, 16'd1700, 16'd1300, 16'd1200, 16'd1100});
    run_poll();

    repeat (20) @(negedge clk);
    check("queues_empty", 96'(exp_q.size() + addr_q.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rc_channel_poller.md
# rc_channel_poller

Wishbone B3 master that sits directly downstream of the 6-channel RC PWM decoder slave. At a fixed poll rate it reads the status register and each ready channel register, and validates every pulse width. It clamps valid values and commits all six channels atomically to a flat output bus for the flight controller. It also raises a failsafe after a run of bad polls.

## Interface
- clockFreq, 100_000_000, system clock in Hz
- POLL_HZ, 250, poll rate; period P = clockFreq/POLL_HZ cycles
- DATA_WIDTH, 32, Wishbone data width
- ADDR_WIDTH, 32, Wishbone address width
- BASE_ADDR, 0, decoder base address; channel n at BASE_ADDR+4n, status at BASE_ADDR+0x18
- MIN_US, 1000, lower clamp for valid values
- MAX_US, 2000, upper clamp for valid values
- FAILSAFE_US, 1000, value forced on all channels in failsafe and at reset
- FAILSAFE_POLLS, 25, consecutive bad polls before failsafe (1..255)

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  asynchronous active-low reset
- wbm_adr_o  out  ADDR_WIDTH  read address
- wbm_dat_i  in  DATA_WIDTH  read data
- wbm_we_o  out  1  always 0
- wbm_sel_o  out  DATA_WIDTH/8  all ones during cycle, else 0
- wbm_stb_o  out  1  strobe
- wbm_cyc_o  out  1  cycle
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  error
- o_ch_us  out  96  channel n in bits [16n+15:16n], microseconds
- o_valid  out  6  per-channel valid flag of last committed poll
- o_update  out  1  one-cycle pulse on commit
- o_failsafe  out  1  failsafe active

## Operation
- Tick counter counts 0..P-1; the wrap sets `pending`. Only one pending tick is held; extra ticks while pending is set are dropped.
- FSM: IDLE -> RD_STAT -> RD_CH (idx 0..5) -> COMMIT -> IDLE. IDLE leaves when pending is set and clears pending.
- Each read: drive cyc=stb=1, sel=all ones, we=0, adr. Hold until ack or err. Deassert cyc/stb on the cycle after ack/err; at least one idle cycle separates reads.
- Bus watchdog: 255 cycles without ack/err aborts the read. An aborted or err status read marks the poll bad and goes to COMMIT with all channels invalid. An aborted or err channel read marks that channel invalid.
- RD_CH skips channel n (no bus cycle, invalid) when status bit n is 0.
- A channel is valid iff data[15]==0 and 800 <= data[15:0] <= 2200. A valid value is clamped to [MIN_US, MAX_US] into a shadow register. An invalid channel's shadow holds the previous value.
- COMMIT: copy shadows to o_ch_us, set o_valid, pulse o_update. The poll is good iff all six channels are valid.
- The bad-poll counter saturates at FAILSAFE_POLLS and clears on a good poll.

## Timing
- Reset: cyc/stb/we=0, sel=0, adr=0, o_ch_us all FAILSAFE_US, shadows FAILSAFE_US, o_valid=0, o_update=0, o_failsafe=1 (0 when feature is out), counters 0, FSM IDLE.
- Against a registered-ack slave, each read takes 2 cycles with stb plus 1 idle cycle. A full poll takes about 22 cycles from IDLE exit to the o_update pulse.
- o_ch_us, o_valid, o_failsafe and o_update all change on the same edge (COMMIT).
- Reset mid-cycle drops cyc/stb immediately and aborts the poll with no commit.
- A tick arriving in the same cycle as COMMIT sets pending; the next poll starts from IDLE on the following cycle.

## Configuration
- RC_POLLER_FAILSAFE_EN defined: when the bad-poll counter reaches FAILSAFE_POLLS, COMMIT sets o_failsafe=1 and forces all o_ch_us to FAILSAFE_US. The first good poll clears o_failsafe and commits live values.
- Not defined: o_failsafe is tied to 0 and the counter is removed. Invalid channels hold their last valid value indefinitely.

## Test plan
- Decoder slave model with status 0x3F and ch0..5 = 1500,1200,900,2100,1000,2000 -> one o_update pulse; o_ch_us = 1500,1200,1000,2000,1000,2000; o_valid=0x3F; o_failsafe 1->0.
- Status 0x3E with ch0 = 0xC000 -> no bus cycle to BASE_ADDR+0x00; o_valid=0x3E; ch0 holds its previous value; poll counted bad.
- FAILSAFE_EN, 25 consecutive polls with ch2 = 0x85DC -> o_failsafe=1 at the 25th COMMIT with all channels 1000. One good poll then clears it.
- Slave withholds ack on the ch3 read -> stb drops after 255 cycles; ch3 invalid; the poll still completes through ch5.
- Slave asserts err on the status read -> o_update pulses with o_valid=0 and the outputs unchanged.
- Assert i_rstn low while stb is high -> cyc/stb are 0 in the same cycle; all outputs return to reset values; no o_update.
